execute_muldiv_unit: RTL and testbench
======================================

# execute_muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, fed by the decode/execute pipeline register alongside the ALU. It takes the forwarded EX operands and the M-extension funct3, holds the pipeline via a busy line to the hazard unit while iterating, and returns a 32-bit result to the EX result mux on a one-cycle done strobe.

## Interface
- DATA_WIDTH, 32, operand/result width (only 32 supported)
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- StartE  input  1  M-extension instruction valid in EX (decoded RegWrite op, opcode OP, funct7=0000001)
- MulDivOpE  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcAE  input  32  rs1 value after forwarding mux
- SrcBE  input  32  rs2 value after forwarding mux
- KillE  input  1  abort in-flight op (flush of EX); synchronous
- BusyE  output  1  stall request to hazard unit (hold F/D/E, bubble M)
- DoneE  output  1  one-cycle strobe: ResultE valid, EX instruction may advance
- ResultE  output  32  result, registered

## Operation
- States: IDLE, MUL, DIV, DONE. Reset: state IDLE, count 0, ResultE 0, DoneE 0; BusyE 0 whenever StartE=0 in IDLE.
- IDLE: on StartE=1 (and KillE=0) latch op, operands, signedness. Signed operands converted to magnitudes, result sign recorded (MUL/MULH: signA^signB; MULHSU: signA only; DIV: signA^signB; REM: signA).
- Fast paths from IDLE straight to DONE, no iteration:
  - DIV/DIVU divisor 0: quotient 0xFFFFFFFF.
  - REM/REMU divisor 0: remainder = SrcAE.
  - DIV with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000; REM: 0.
- MUL: 64-bit shift-add of magnitudes, one multiplier bit per cycle, 32 iterations (count 0..31). Final 64-bit product negated (two's complement over 64 bits) if sign set. MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32].
- DIV: restoring division of magnitudes, one quotient bit per cycle, 32 iterations; 33-bit partial remainder. Quotient negated if sign set (DIV); remainder negated if dividend negative (REM). Unsigned ops never negate.
- Sign fix-up and result selection happen on the transition into DONE; ResultE register written then.
- DONE: DoneE=1, BusyE=0, one cycle, then IDLE. StartE is ignored in DONE (same instruction still in EX).
- ResultE holds its value after DONE until the next op completes.
- KillE=1 in any state: next state IDLE, count 0, DoneE 0, ResultE unchanged; KillE wins over StartE in IDLE.
- rst mid-operation: identical to reset; no DoneE.

## Timing
- BusyE = (IDLE & StartE & ~KillE) | MUL | DIV; combinational from state and StartE.
- StartE sampled in IDLE at cycle T: iterating ops occupy MUL/DIV T+1..T+32, DONE at T+33. BusyE high T..T+32, low at T+33 with DoneE=1.
- Fast path: BusyE high at T only, DONE (DoneE=1) at T+1.
- Operands are captured at T; SrcAE/SrcBE changes during iteration (forwarding updates while stalled) have no effect.
- Back-to-back ops: new StartE accepted in the IDLE cycle after DONE (T+34 earliest for a following iterating op).
- Throughput: one op per 34 cycles (iterating), per 2 cycles (fast path).

## Test plan
- MUL 7 × 0xFFFFFFFD at T -> BusyE high T..T+32, DoneE at T+33, ResultE 0xFFFFFFEB; MULHU same operands -> 0x00000006.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; all at T+33.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, DoneE at T+1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0 at T+1.
- KillE at T+10 of a DIV -> IDLE at T+11, BusyE 0, no DoneE, ResultE keeps prior value; rst at T+5 -> same, ResultE 0.
- StartE held through DONE then a second MUL presented at T+34 -> exactly one DoneE per op (T+33, T+67), no double start.

Source files
------------

// File: rtl/execute_muldiv_unit_if.sv
// Execute-stage M-extension port bundle: start/kill and operands in, busy/done/result out.
interface execute_muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  StartE;
    logic [2:0]            MulDivOpE;
    logic [DATA_WIDTH-1:0] SrcAE;
    logic [DATA_WIDTH-1:0] SrcBE;
    logic                  KillE;
    logic                  BusyE;
    logic                  DoneE;
    logic [DATA_WIDTH-1:0] ResultE;

    // Pipeline side drives the request, the unit answers with busy/done/result.
    modport master (
        output StartE, MulDivOpE, SrcAE, SrcBE, KillE,
        input  BusyE, DoneE, ResultE
    );

    modport slave (
        input  StartE, MulDivOpE, SrcAE, SrcBE, KillE,
        output BusyE, DoneE, ResultE
    );
endinterface

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Multiplies by shift-add and divides by restoring division, one bit per cycle,
// on operand magnitudes; signs are re-applied when entering DONE.
// Divide-by-zero and signed-overflow divides skip iteration entirely.
module execute_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    execute_muldiv_unit_if.slave  ex_io
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic [W-1:0]     result_q, result_d;
    logic             busy;

    // Operand decode at start: signedness, magnitudes, result sign and fast-path detection.
    logic [2:0]       opIn;
    logic             aSigned, bSigned, signA, signB, negStart;
    logic [W-1:0]     magA, magB;
    logic             divByZero, divOverflow, fastPath;
    logic [W-1:0]     fastResult;

    // One iteration step of each datapath and the sign-corrected final results.
    logic [W:0]       mulSum;
    logic [W-1:0]     mulHiNext, mulLoNext;
    logic [2*W-1:0]   product, productFix;
    logic [W-1:0]     mulResult;
    logic [W:0]       divShift, divDiff;
    logic             divFits;
    logic [W-1:0]     divHiNext, divLoNext;
    logic [W-1:0]     quotFix, remFix, divResult;

    // Decode the incoming instruction and compute step results for the current iteration.
    always_comb begin
        opIn        = ex_io.MulDivOpE;
        aSigned     = opIn[2] ? ~opIn[0] : (opIn[1:0] != 2'b11);
        bSigned     = opIn[2] ? ~opIn[0] : ~opIn[1];
        signA       = aSigned & ex_io.SrcAE[W-1];
        signB       = bSigned & ex_io.SrcBE[W-1];
        magA        = signA ? -ex_io.SrcAE : ex_io.SrcAE;
        magB        = signB ? -ex_io.SrcBE : ex_io.SrcBE;
        negStart    = (opIn[2] & opIn[1]) ? signA : (signA ^ signB);

        divByZero   = opIn[2] & (ex_io.SrcBE == '0);
        divOverflow = opIn[2] & ~opIn[0]
                    & (ex_io.SrcAE == {1'b1, {(W-1){1'b0}}})
                    & (ex_io.SrcBE == '1);
        fastPath    = divByZero | divOverflow;
        if (divByZero) begin
            fastResult = opIn[1] ? ex_io.SrcAE : '1;
        end else begin
            fastResult = opIn[1] ? '0 : {1'b1, {(W-1){1'b0}}};
        end

        mulSum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mulHiNext   = mulSum[W:1];
        mulLoNext   = {mulSum[0], lo_q[W-1:1]};
        product     = {mulHiNext, mulLoNext};
        productFix  = neg_q ? -product : product;
        mulResult   = (op_q == 2'b00) ? productFix[W-1:0] : productFix[2*W-1:W];

        divShift    = {hi_q, lo_q[W-1]};
        divDiff     = divShift - {1'b0, opnd_q};
        divFits     = ~divDiff[W];
        divHiNext   = divFits ? divDiff[W-1:0] : divShift[W-1:0];
        divLoNext   = {lo_q[W-2:0], divFits};
        quotFix     = neg_q ? -divLoNext : divLoNext;
        remFix      = neg_q ? -divHiNext : divHiNext;
        divResult   = op_q[1] ? remFix : quotFix;
    end

    // Next-state logic: accept in IDLE, iterate 32 steps, hold DONE one cycle; KillE aborts.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        busy     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_io.StartE && !ex_io.KillE) begin
                    busy    = 1'b1;
                    op_d    = opIn[1:0];
                    neg_d   = negStart;
                    count_d = 5'd0;
                    hi_d    = '0;
                    if (fastPath) begin
                        result_d = fastResult;
                        state_d  = DONE;
                    end else if (opIn[2]) begin
                        lo_d    = magA;
                        opnd_d  = magB;
                        state_d = DIV;
                    end else begin
                        lo_d    = magB;
                        opnd_d  = magA;
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                busy    = 1'b1;
                hi_d    = mulHiNext;
                lo_d    = mulLoNext;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    result_d = mulResult;
                    count_d  = 5'd0;
                    state_d  = DONE;
                end
            end
            DIV: begin
                busy    = 1'b1;
                hi_d    = divHiNext;
                lo_d    = divLoNext;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    result_d = divResult;
                    count_d  = 5'd0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (ex_io.KillE) begin
            state_d  = IDLE;
            count_d  = 5'd0;
            result_d = result_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= 5'd0;
            op_q     <= 2'b00;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

    assign ex_io.BusyE   = busy;
    assign ex_io.DoneE   = (state_q == DONE);
    assign ex_io.ResultE = result_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed testbench for execute_muldiv_unit: results, latency, kill, reset and back-to-back.
module tb_execute_muldiv_unit;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    execute_muldiv_unit_if #(.DATA_WIDTH(32)) exIf ();

    execute_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .ex_io (exIf)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present an instruction in cycle T and confirm the stall request goes up immediately.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        @(negedge clk);
        exIf.StartE    = 1'b1;
        exIf.MulDivOpE = op;
        exIf.SrcAE     = a;
        exIf.SrcBE     = b;
        #1;
        checkOutput("busyAtStart", {31'd0, exIf.BusyE}, 32'd1);
    endtask

    // Run one op to completion, scrambling the operand buses while it iterates.
    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expResult,
                         input int expLatency);
        int cyc;
        int busyDrop;
        applyStimulus(op, a, b);
        @(negedge clk);
        exIf.StartE    = 1'b0;
        exIf.SrcAE     = $urandom;
        exIf.SrcBE     = $urandom;
        exIf.MulDivOpE = 3'($urandom);
        cyc      = 1;
        busyDrop = 0;
        while (exIf.DoneE !== 1'b1 && cyc < 60) begin
            if (exIf.BusyE !== 1'b1) busyDrop++;
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, " latency"}, 32'(cyc), 32'(expLatency));
        checkOutput({tag, " busyDrop"}, 32'(busyDrop), 32'd0);
        checkOutput({tag, " busyAtDone"}, {31'd0, exIf.BusyE}, 32'd0);
        checkOutput({tag, " result"}, exIf.ResultE, expResult);
        @(negedge clk);
        checkOutput({tag, " doneOneCycle"}, {31'd0, exIf.DoneE}, 32'd0);
        checkOutput({tag, " resultHeld"}, exIf.ResultE, expResult);
    endtask

    initial begin
        int doneCount;
        int firstDone;
        int secondDone;

        rst            = 1'b1;
        exIf.StartE    = 1'b0;
        exIf.KillE     = 1'b0;
        exIf.MulDivOpE = 3'b000;
        exIf.SrcAE     = 32'd0;
        exIf.SrcBE     = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("resetResult", exIf.ResultE, 32'd0);
        checkOutput("resetDone", {31'd0, exIf.DoneE}, 32'd0);
        checkOutput("resetBusy", {31'd0, exIf.BusyE}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idleBusy", {31'd0, exIf.BusyE}, 32'd0);

        $display("[TB] multiply ops");
        runOp("MUL",    OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        runOp("MULHU",  OP_MULHU,  32'd7,        32'hFFFFFFFD, 32'h00000006, 33);
        runOp("MULH",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
        runOp("MULHSU", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        runOp("MULHneg", OP_MULH,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 33);

        $display("[TB] divide ops");
        runOp("DIV",  OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        runOp("REM",  OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        runOp("DIVU", OP_DIVU, 32'd100,      32'd7, 32'd14,       33);
        runOp("REMU", OP_REMU, 32'd100,      32'd7, 32'd2,        33);

        $display("[TB] kill mid-divide");
        applyStimulus(OP_DIV, 32'd1000, 32'd3);
        @(negedge clk);
        exIf.StartE = 1'b0;
        repeat (9) @(negedge clk);
        exIf.KillE = 1'b1;
        @(negedge clk);
        exIf.KillE = 1'b0;
        checkOutput("killBusy", {31'd0, exIf.BusyE}, 32'd0);
        checkOutput("killDone", {31'd0, exIf.DoneE}, 32'd0);
        checkOutput("killResult", exIf.ResultE, 32'd2);
        doneCount = 0;
        repeat (40) begin
            @(negedge clk);
            if (exIf.DoneE === 1'b1) doneCount++;
        end
        checkOutput("killNoDone", 32'(doneCount), 32'd0);

        $display("[TB] fast paths");
        runOp("DIVovf", OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        runOp("REMovf", OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        runOp("DIVU0",  OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        runOp("REM0",   OP_REM,  32'd5,        32'd0,        32'd5,        1);

        $display("[TB] reset mid-multiply");
        applyStimulus(OP_MUL, 32'd7, 32'hFFFFFFFD);
        @(negedge clk);
        exIf.StartE = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstBusy", {31'd0, exIf.BusyE}, 32'd0);
        checkOutput("rstDone", {31'd0, exIf.DoneE}, 32'd0);
        checkOutput("rstResult", exIf.ResultE, 32'd0);
        doneCount = 0;
        repeat (40) begin
            @(negedge clk);
            if (exIf.DoneE === 1'b1) doneCount++;
        end
        checkOutput("rstNoDone", 32'(doneCount), 32'd0);

        $display("[TB] back-to-back with StartE held");
        applyStimulus(OP_MUL, 32'd7, 32'hFFFFFFFD);
        doneCount  = 0;
        firstDone  = -1;
        secondDone = -1;
        for (int cyc = 1; cyc <= 75; cyc++) begin
            @(negedge clk);
            if (exIf.DoneE === 1'b1) begin
                doneCount++;
                if (firstDone < 0) firstDone = cyc;
                else if (secondDone < 0) secondDone = cyc;
            end
            if (cyc == 34) begin
                exIf.SrcAE = 32'd5;
                exIf.SrcBE = 32'd6;
            end
            if (cyc == 35) exIf.StartE = 1'b0;
        end
        checkOutput("b2bDoneCount", 32'(doneCount), 32'd2);
        checkOutput("b2bFirstDone", 32'(firstDone), 32'd33);
        checkOutput("b2bSecondDone", 32'(secondDone), 32'd67);
        checkOutput("b2bResult", exIf.ResultE, 32'd30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
